// File: rtl/csync_gen.sv
// csync_gen: composite-sync builder and two-stage timing aligner.
// Measures the incoming line period and hsync width, then emits a composite
// sync that follows hsync outside vsync and carries serrated broad pulses
// during vsync. Pixel data and h/v sync are forwarded with the same 2-clock
// latency as the generated sync.
module csync_gen #(
  parameter int CNT_W   = 12,
  parameter int VIDEO_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hsync,
  input  logic               vsync,
  input  logic [VIDEO_W-1:0] din,
  output logic [VIDEO_W-1:0] dout,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               csync_o,
  output logic               locked
);

  localparam logic [CNT_W-1:0]        CNT_MAX = '1;
  localparam logic [CNT_W-1:0]        CNT_ONE = CNT_W'(1);
  localparam logic signed [CNT_W:0]   TOL     = (CNT_W+1)'(2);

  // Stage 1 registers
  logic               hs_r;
  logic               vs_r;
  logic               hs_d;
  logic [VIDEO_W-1:0] din_r;

  // Measurement state
  logic [CNT_W-1:0]   h_cnt;
  logic [CNT_W-1:0]   hw_cnt;
  logic [CNT_W-1:0]   hs_width;
  logic [CNT_W-1:0]   line_len;
  logic               valid;

  // Combinational helpers
  logic               rise;
  logic               fall;
  logic               h_sat;
  logic [CNT_W-1:0]   p;
  logic [CNT_W:0]     meas;
  logic signed [CNT_W:0] meas_diff;
  logic               within_tol;
  logic [CNT_W-1:0]   half;
  logic [CNT_W-1:0]   q;
  logic               serr;
  logic               cs_next;

  assign rise  = hs_r & ~hs_d;
  assign fall  = ~hs_r & hs_d;
  assign h_sat = (h_cnt == CNT_MAX);

  // Position within the line as seen this cycle (equals the next h_cnt).
  assign p = rise ? '0 : (h_sat ? h_cnt : h_cnt + CNT_ONE);

  // Length of the line that ends on this rise; only used when h_cnt has not
  // saturated, so the top bit stays clear in every case that updates line_len.
  assign meas       = {1'b0, h_cnt} + {1'b0, CNT_ONE};
  assign meas_diff  = $signed(meas) - $signed({1'b0, line_len});
  assign within_tol = (meas_diff <= TOL) && (meas_diff >= -TOL);

  // Serration: two broad pulses per line, each ending hs_width clocks before
  // the half-line and the line boundary.
  always_comb begin
    half    = line_len >> 1;
    q       = p;
    serr    = 1'b0;
    cs_next = hs_r;
    if (p >= half) begin
      q = p - half;
    end
    serr = (half > hs_width) && (q < (half - hs_width));
    if (vs_r && locked) begin
      cs_next = serr;
    end
  end

  // Stage 1: capture inputs and remember the previous hsync level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_r  <= 1'b0;
      vs_r  <= 1'b0;
      hs_d  <= 1'b0;
      din_r <= '0;
    end else begin
      hs_r  <= hsync;
      vs_r  <= vsync;
      hs_d  <= hs_r;
      din_r <= din;
    end
  end

  // Line position and hsync width counters, both saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt    <= '0;
      hw_cnt   <= '0;
      hs_width <= '0;
    end else begin
      h_cnt <= p;
      if (rise) begin
        hw_cnt <= CNT_ONE;
      end else if (hs_r && (hw_cnt != CNT_MAX)) begin
        hw_cnt <= hw_cnt + CNT_ONE;
      end
      if (fall) begin
        hs_width <= hw_cnt;
      end
    end
  end

  // Line-length tracking and lock decision, evaluated on each hsync rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_len <= '0;
      valid    <= 1'b0;
      locked   <= 1'b0;
    end else if (rise) begin
      if (!valid || h_sat) begin
        // Partial or overlong line: discard it, next rise measures a full line.
        locked <= 1'b0;
        valid  <= 1'b1;
      end else if (line_len == '0) begin
        line_len <= meas[CNT_W-1:0];
      end else begin
        locked   <= within_tol;
        line_len <= meas[CNT_W-1:0];
      end
    end
  end

  // Stage 2: matched output register for data, syncs and composite sync.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout    <= '0;
      hsync_o <= 1'b0;
      vsync_o <= 1'b0;
      csync_o <= 1'b0;
    end else begin
      dout    <= din_r;
      hsync_o <= hs_r;
      vsync_o <= vs_r;
      csync_o <= cs_next;
    end
  end

endmodule

// File: tb/tb_csync_gen.sv
// Testbench for csync_gen: scenario tasks driving line-shaped stimulus with
// random pixel data, checked against a cycle model built from line timing.
module tb_csync_gen;

  localparam int CAP = 4095;

  logic        clk;
  logic        reset;
  logic        hsync;
  logic        vsync;
  logic [23:0] din;
  logic [23:0] dout;
  logic        hsync_o;
  logic        vsync_o;
  logic        csync_o;
  logic        locked;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state (plain integers)
  logic        m_hs1, m_vs1, m_hsprev, m_seen, m_locked;
  logic [23:0] m_d1;
  int          m_pos, m_run, m_width, m_len;
  logic [23:0] e_dout;
  logic        e_hs, e_vs, e_cs, e_lock;

  csync_gen #(.CNT_W(12), .VIDEO_W(24)) dut (
    .clk     (clk),
    .reset   (reset),
    .hsync   (hsync),
    .vsync   (vsync),
    .din     (din),
    .dout    (dout),
    .hsync_o (hsync_o),
    .vsync_o (vsync_o),
    .csync_o (csync_o),
    .locked  (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_hs1 = 0; m_vs1 = 0; m_hsprev = 0; m_seen = 0; m_locked = 0;
    m_d1 = '0; m_pos = 0; m_run = 0; m_width = 0; m_len = 0;
    e_dout = '0; e_hs = 0; e_vs = 0; e_cs = 0; e_lock = 0;
  endtask

  // One clock of the reference: outputs come from the sample captured one
  // clock earlier; line length is the distance between consecutive rises.
  task automatic model_edge(input logic h, input logic v, input logic [23:0] d);
    logic rise, fall, cs;
    int p, half, q, line;
    rise = m_hs1 && !m_hsprev;
    fall = !m_hs1 && m_hsprev;
    p = rise ? 0 : ((m_pos + 1 > CAP) ? CAP : m_pos + 1);
    if (m_vs1 && m_locked) begin
      half = m_len / 2;
      q    = (p < half) ? p : p - half;
      cs   = (half > m_width) && (q < half - m_width);
    end else begin
      cs = m_hs1;
    end
    e_dout = m_d1; e_hs = m_hs1; e_vs = m_vs1; e_cs = cs;
    if (rise) begin
      line = m_pos + 1;
      if (!m_seen || m_pos == CAP) begin
        m_locked = 0;
        m_seen   = 1;
      end else if (m_len == 0) begin
        m_len = line;
      end else begin
        m_locked = (line - m_len <= 2) && (m_len - line <= 2);
        m_len    = line;
      end
    end
    m_pos = p;
    if (rise) m_run = 1;
    else if (m_hs1 && m_run < CAP) m_run = m_run + 1;
    if (fall) m_width = m_run;
    e_lock = m_locked;
    m_hsprev = m_hs1; m_hs1 = h; m_vs1 = v; m_d1 = d;
  endtask

  task automatic tick(input logic h, input logic v, input logic [23:0] d);
    hsync = h; vsync = v; din = d;
    @(posedge clk);
    #1;
    if (reset) model_reset();
    else model_edge(h, v, d);
  endtask

  task automatic test_reset();
    reset = 1'b1; hsync = 0; vsync = 0; din = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({dout, hsync_o, vsync_o, csync_o, locked} !== 28'h0) begin
      n_fails++;
      $display("FAIL reset_state got=%h exp=%h", {dout, hsync_o, vsync_o, csync_o, locked}, 28'h0);
    end
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_lock();
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 100; i++) begin
        tick(i < 8, 1'b0, 24'($urandom));
        n_checks++;
        if ({dout, hsync_o, vsync_o, csync_o, locked} !== {e_dout, e_hs, e_vs, e_cs, e_lock}) begin
          n_fails++;
          $display("FAIL lock_model t=%0t got=%h exp=%h", $time,
                   {dout, hsync_o, vsync_o, csync_o, locked}, {e_dout, e_hs, e_vs, e_cs, e_lock});
        end
        n_checks++;
        if (csync_o !== hsync_o) begin
          n_fails++;
          $display("FAIL lock_csync_follow t=%0t got=%b exp=%b", $time, csync_o, hsync_o);
        end
        if (l == 2 && i == 0) begin
          n_checks++;
          if (locked !== 1'b0) begin
            n_fails++;
            $display("FAIL lock_early t=%0t got=%b exp=0", $time, locked);
          end
        end
        if (l == 2 && i == 1) begin
          n_checks++;
          if (locked !== 1'b1) begin
            n_fails++;
            $display("FAIL lock_third_rise t=%0t got=%b exp=1", $time, locked);
          end
        end
      end
    end
    $display("test_lock done");
  endtask

  task automatic test_serration();
    int   off;
    logic prev;
    logic exp_cs;
    off  = 0;
    prev = hsync_o;
    for (int l = 0; l < 5; l++) begin
      for (int i = 0; i < 100; i++) begin
        tick(i < 8, l < 3, 24'($urandom));
        n_checks++;
        if ({dout, hsync_o, vsync_o, csync_o, locked} !== {e_dout, e_hs, e_vs, e_cs, e_lock}) begin
          n_fails++;
          $display("FAIL serr_model t=%0t got=%h exp=%h", $time,
                   {dout, hsync_o, vsync_o, csync_o, locked}, {e_dout, e_hs, e_vs, e_cs, e_lock});
        end
        if (hsync_o && !prev) off = 0;
        else off = off + 1;
        prev = hsync_o;
        n_checks++;
        if (vsync_o === 1'b1) begin
          exp_cs = (off < 42) || (off >= 50 && off < 92);
          if (csync_o !== exp_cs) begin
            n_fails++;
            $display("FAIL serr_pattern off=%0d got=%b exp=%b", off, csync_o, exp_cs);
          end
        end else if (csync_o !== hsync_o) begin
          n_fails++;
          $display("FAIL serr_follow t=%0t got=%b exp=%b", $time, csync_o, hsync_o);
        end
      end
    end
    $display("test_serration done");
  endtask

  task automatic test_jitter();
    int   lens [7];
    logic exp_lk [6];
    lens   = '{101, 99, 104, 104, 100, 100, 100};
    exp_lk = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int j = 0; j < 7; j++) begin
      for (int i = 0; i < lens[j]; i++) begin
        tick(i < 8, 1'b0, 24'($urandom));
        n_checks++;
        if ({dout, hsync_o, vsync_o, csync_o, locked} !== {e_dout, e_hs, e_vs, e_cs, e_lock}) begin
          n_fails++;
          $display("FAIL jitter_model t=%0t got=%h exp=%h", $time,
                   {dout, hsync_o, vsync_o, csync_o, locked}, {e_dout, e_hs, e_vs, e_cs, e_lock});
        end
        if (j >= 1 && i == 1) begin
          n_checks++;
          if (locked !== exp_lk[j-1]) begin
            n_fails++;
            $display("FAIL jitter_lock line=%0d got=%b exp=%b", j - 1, locked, exp_lk[j-1]);
          end
        end
      end
    end
    $display("test_jitter done");
  endtask

  task automatic test_missing();
    for (int i = 0; i < 5000; i++) begin
      tick(i < 8, 1'b0, 24'($urandom));
      n_checks++;
      if ({dout, hsync_o, vsync_o, csync_o, locked} !== {e_dout, e_hs, e_vs, e_cs, e_lock}) begin
        n_fails++;
        $display("FAIL missing_model_long t=%0t got=%h exp=%h", $time,
                 {dout, hsync_o, vsync_o, csync_o, locked}, {e_dout, e_hs, e_vs, e_cs, e_lock});
      end
    end
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 100; i++) begin
        tick(i < 8, 1'b0, 24'($urandom));
        n_checks++;
        if ({dout, hsync_o, vsync_o, csync_o, locked} !== {e_dout, e_hs, e_vs, e_cs, e_lock}) begin
          n_fails++;
          $display("FAIL missing_model t=%0t got=%h exp=%h", $time,
                   {dout, hsync_o, vsync_o, csync_o, locked}, {e_dout, e_hs, e_vs, e_cs, e_lock});
        end
        if (l == 0 && i == 1) begin
          n_checks++;
          if (locked !== 1'b0) begin
            n_fails++;
            $display("FAIL missing_unlock t=%0t got=%b exp=0", $time, locked);
          end
        end
      end
    end
    $display("test_missing done");
  endtask

  task automatic test_async_reset();
    for (int i = 0; i <= 37; i++) begin
      tick(i < 8, 1'b0, 24'($urandom));
      n_checks++;
      if ({dout, hsync_o, vsync_o, csync_o, locked} !== {e_dout, e_hs, e_vs, e_cs, e_lock}) begin
        n_fails++;
        $display("FAIL areset_pre_model t=%0t got=%h exp=%h", $time,
                 {dout, hsync_o, vsync_o, csync_o, locked}, {e_dout, e_hs, e_vs, e_cs, e_lock});
      end
    end
    #2 reset = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if ({dout, hsync_o, vsync_o, csync_o, locked} !== 28'h0) begin
      n_fails++;
      $display("FAIL areset_immediate got=%h exp=%h", {dout, hsync_o, vsync_o, csync_o, locked}, 28'h0);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 24'($urandom));
      n_checks++;
      if ({dout, hsync_o, vsync_o, csync_o, locked} !== 28'h0) begin
        n_fails++;
        $display("FAIL areset_hold got=%h exp=%h", {dout, hsync_o, vsync_o, csync_o, locked}, 28'h0);
      end
    end
    reset = 1'b0;
    for (int i = 41; i < 100; i++) begin
      tick(1'b0, 1'b0, 24'($urandom));
      n_checks++;
      if ({dout, hsync_o, vsync_o, csync_o, locked} !== {e_dout, e_hs, e_vs, e_cs, e_lock}) begin
        n_fails++;
        $display("FAIL areset_partial_model t=%0t got=%h exp=%h", $time,
                 {dout, hsync_o, vsync_o, csync_o, locked}, {e_dout, e_hs, e_vs, e_cs, e_lock});
      end
    end
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 100; i++) begin
        tick(i < 8, 1'b0, 24'($urandom));
        n_checks++;
        if ({dout, hsync_o, vsync_o, csync_o, locked} !== {e_dout, e_hs, e_vs, e_cs, e_lock}) begin
          n_fails++;
          $display("FAIL areset_model t=%0t got=%h exp=%h", $time,
                   {dout, hsync_o, vsync_o, csync_o, locked}, {e_dout, e_hs, e_vs, e_cs, e_lock});
        end
        if (l == 2 && (i == 0 || i == 1)) begin
          n_checks++;
          if (locked !== (i == 1)) begin
            n_fails++;
            $display("FAIL areset_relock off=%0d got=%b exp=%b", i, locked, (i == 1));
          end
        end
      end
    end
    $display("test_async_reset done");
  endtask

  task automatic test_degenerate();
    for (int l = 0; l < 6; l++) begin
      for (int i = 0; i < 100; i++) begin
        tick(i < 60, (l == 3 || l == 4), 24'($urandom));
        n_checks++;
        if ({dout, hsync_o, vsync_o, csync_o, locked} !== {e_dout, e_hs, e_vs, e_cs, e_lock}) begin
          n_fails++;
          $display("FAIL degen_model t=%0t got=%h exp=%h", $time,
                   {dout, hsync_o, vsync_o, csync_o, locked}, {e_dout, e_hs, e_vs, e_cs, e_lock});
        end
        if (vsync_o === 1'b1) begin
          n_checks++;
          if (csync_o !== 1'b0) begin
            n_fails++;
            $display("FAIL degen_zero t=%0t got=%b exp=0", $time, csync_o);
          end
        end
      end
    end
    $display("test_degenerate done");
  endtask

  task automatic test_random();
    int   per, w, tog;
    logic va, vb;
    for (int l = 0; l < 25; l++) begin
      per = $urandom_range(106, 94);
      w   = $urandom_range(24, 3);
      tog = $urandom_range(per - 1, 0);
      va  = 1'($urandom);
      vb  = 1'($urandom);
      for (int i = 0; i < per; i++) begin
        tick(i < w, (i < tog) ? va : vb, 24'($urandom));
        n_checks++;
        if ({dout, hsync_o, vsync_o, csync_o, locked} !== {e_dout, e_hs, e_vs, e_cs, e_lock}) begin
          n_fails++;
          $display("FAIL random_model line=%0d off=%0d got=%h exp=%h", l, i,
                   {dout, hsync_o, vsync_o, csync_o, locked}, {e_dout, e_hs, e_vs, e_cs, e_lock});
        end
      end
      $display("random line %0d period=%0d width=%0d locked=%b", l, per, w, locked);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_serration();
    test_jitter();
    test_missing();
    test_async_reset();
    test_degenerate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
